// File: rtl/uart_tx.sv
// UART transmitter: start bits, LSB-first data, optional parity, stop bits.
// Ports: i_clk, i_rst (sync, high); i_user_tx_data/i_user_tx_valid in;
//        o_user_tx_ready (high only when idle), o_uart_tx (serial line, idle high).
module uart_tx #(
    parameter int P_UART_BUADRATE    = 115200,
    parameter int P_SYSTEM_CLK       = 100000000,
    parameter int P_UART_START_WIDTH = 1,
    parameter int P_UART_DATA_WIDTH  = 8,
    parameter int P_UART_STOP_WIDTH  = 1,
    parameter int P_UART_CHECK       = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
    input  logic                         i_user_tx_valid,
    output logic                         o_user_tx_ready,
    output logic                         o_uart_tx
);

    localparam int          N          = P_SYSTEM_CLK / P_UART_BUADRATE;
    localparam logic [15:0] BAUD_LAST  = 16'(N - 1);
    localparam logic [7:0]  START_LAST = 8'(P_UART_START_WIDTH - 1);
    localparam logic [7:0]  DATA_LAST  = 8'(P_UART_DATA_WIDTH - 1);
    localparam logic [7:0]  STOP_LAST  = 8'(P_UART_STOP_WIDTH - 1);
    // Unsupported parity codes fall back to no parity.
    localparam bit          CHK_EN     = (P_UART_CHECK == 1) || (P_UART_CHECK == 2);
    localparam bit          CHK_ODD    = (P_UART_CHECK == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_CHECK,
        S_STOP
    } state_t;

    state_t                       state_q, state_n;
    logic [15:0]                  baud_q, baud_n;
    logic [7:0]                   bit_q, bit_n;
    logic [P_UART_DATA_WIDTH-1:0] shreg_q, shreg_n;
    logic                         par_q, par_n;
    logic                         tx_q, tx_n;
    logic                         rdy_q, rdy_n;
    logic                         baud_end;

    assign baud_end        = (baud_q == BAUD_LAST);
    assign o_uart_tx       = tx_q;
    assign o_user_tx_ready = rdy_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            shreg_q <= shreg_n;
            par_q   <= par_n;
            tx_q    <= tx_n;
            rdy_q   <= rdy_n;
        end
    end

    always_comb begin
        state_n = state_q;
        baud_n  = baud_end ? 16'd0 : baud_q + 16'd1;
        bit_n   = bit_q;
        shreg_n = shreg_q;
        par_n   = par_q;
        tx_n    = tx_q;
        rdy_n   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                baud_n = '0;
                bit_n  = '0;
                tx_n   = 1'b1;
                rdy_n  = 1'b1;
                if (i_user_tx_valid && rdy_q) begin
                    // Parity is taken from the word as captured, before shifting.
                    shreg_n = i_user_tx_data;
                    par_n   = (^i_user_tx_data) ^ CHK_ODD;
                    state_n = S_START;
                    tx_n    = 1'b0;
                    rdy_n   = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    if (bit_q == START_LAST) begin
                        bit_n   = '0;
                        state_n = S_DATA;
                        tx_n    = shreg_q[0];
                    end else begin
                        bit_n = bit_q + 8'd1;
                    end
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_n = '0;
                        if (CHK_EN) begin
                            state_n = S_CHECK;
                            tx_n    = par_q;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_q + 8'd1;
                        shreg_n = shreg_q >> 1;
                        tx_n    = shreg_n[0];
                    end
                end
            end
            S_CHECK: begin
                if (baud_end) begin
                    bit_n   = '0;
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                end
            end
            S_STOP: begin
                tx_n = 1'b1;
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_n   = '0;
                        state_n = S_IDLE;
                        rdy_n   = 1'b1;
                    end else begin
                        bit_n = bit_q + 8'd1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
                rdy_n   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (even, odd, none, code 3) with N=4.
// Expected line/ready per clock queued at stimulus time, popped each cycle.
module tb_uart_tx;

    typedef struct packed {
        logic tx;
        logic rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       valid [4];
    logic       tx    [4];
    logic       rdy   [4];
    int         mode_of [4] = '{1, 2, 0, 3};
    int         sel = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    exp_t       exp_q [$];

    always #5 clk = ~clk;

    uart_tx #(.P_UART_BUADRATE(100), .P_SYSTEM_CLK(400), .P_UART_CHECK(1)) u_even (
        .i_clk(clk), .i_rst(i_rst), .i_user_tx_data(tx_data),
        .i_user_tx_valid(valid[0]), .o_user_tx_ready(rdy[0]), .o_uart_tx(tx[0]));
    uart_tx #(.P_UART_BUADRATE(100), .P_SYSTEM_CLK(400), .P_UART_CHECK(2)) u_odd (
        .i_clk(clk), .i_rst(i_rst), .i_user_tx_data(tx_data),
        .i_user_tx_valid(valid[1]), .o_user_tx_ready(rdy[1]), .o_uart_tx(tx[1]));
    uart_tx #(.P_UART_BUADRATE(100), .P_SYSTEM_CLK(400), .P_UART_CHECK(0)) u_none (
        .i_clk(clk), .i_rst(i_rst), .i_user_tx_data(tx_data),
        .i_user_tx_valid(valid[2]), .o_user_tx_ready(rdy[2]), .o_uart_tx(tx[2]));
    uart_tx #(.P_UART_BUADRATE(100), .P_SYSTEM_CLK(400), .P_UART_CHECK(3)) u_bad (
        .i_clk(clk), .i_rst(i_rst), .i_user_tx_data(tx_data),
        .i_user_tx_valid(valid[3]), .o_user_tx_ready(rdy[3]), .o_uart_tx(tx[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("line", 32'(tx[sel]), 32'(e.tx));
            check("ready", 32'(rdy[sel]), 32'(e.rdy));
        end
    end

    task automatic push_exp(input logic t, input logic r, input int n);
        repeat (n) exp_q.push_back(exp_t'({t, r}));
    endtask

    task automatic push_frame(input int mode, input logic [7:0] d);
        push_exp(1'b0, 1'b0, 4);
        for (int i = 0; i < 8; i++) push_exp(d[i], 1'b0, 4);
        if (mode == 1) push_exp(^d, 1'b0, 4);
        else if (mode == 2) push_exp(~^d, 1'b0, 4);
        push_exp(1'b1, 1'b0, 4);
        push_exp(1'b1, 1'b1, 1);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!rdy[sel] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rdy[sel]) check("ready_wait", 32'(rdy[sel]), 32'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("drain", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic send(input logic [7:0] d, input bit keep);
        wait_ready();
        tx_data    = d;
        valid[sel] = 1'b1;
        push_frame(mode_of[sel], d);
        @(posedge clk);
        @(negedge clk);
        if (!keep) valid[sel] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_line", 32'(tx[i]), 32'd1);
            check("rst_ready", 32'(rdy[i]), 32'd1);
        end

        // Handshake coinciding with reset is dropped.
        sel      = 0;
        tx_data  = 8'hAA;
        valid[0] = 1'b1;
        push_exp(1'b1, 1'b1, 1);
        @(negedge clk);
        i_rst    = 1'b0;
        valid[0] = 1'b0;
        push_exp(1'b1, 1'b1, 5);
        drain();

        sel = 0; send(8'hA5, 1'b0); drain();
        sel = 1; send(8'hA5, 1'b0); drain();
        sel = 2; send(8'h00, 1'b0); drain();
        sel = 3; send(8'h5A, 1'b0); drain();
        sel = 1; send(8'h3E, 1'b0); drain();

        // Back-to-back with valid held high.
        sel = 0;
        send(8'h01, 1'b1);
        send(8'h80, 1'b0);
        drain();
        push_exp(1'b1, 1'b1, 3);
        drain();

        // Reset at edge k+10 aborts the frame.
        send(8'h55, 1'b0);
        repeat (9) @(negedge clk);
        exp_q.delete();
        push_exp(1'b1, 1'b1, 1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        push_exp(1'b1, 1'b1, 6);
        drain();
        send(8'h3C, 1'b0);
        drain();

        // Valid while busy is ignored; data change mid-frame has no effect.
        send(8'h96, 1'b0);
        repeat (12) @(negedge clk);
        tx_data  = 8'hFF;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        drain();
        push_exp(1'b1, 1'b1, 10);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter P_UART_BUADRATE, default 115200, line bit rate in bit/s.
REQ-002 Parameter P_SYSTEM_CLK, default 100000000, i_clk frequency in Hz.
REQ-003 Parameter P_UART_START_WIDTH, default 1, number of start bits.
REQ-004 Parameter P_UART_DATA_WIDTH, default 8, data bits per frame.
REQ-005 Parameter P_UART_STOP_WIDTH, default 1, number of stop bits.
REQ-006 Parameter P_UART_CHECK, default 1, parity mode: 0 = none, 1 = even (parity bit = XOR of data bits), 2 = odd (parity bit = inverted XOR).
REQ-007 i_clk, input, 1, single system clock; all logic on rising edge.
REQ-008 i_rst, input, 1, reset, synchronous and active-high.
REQ-009 i_user_tx_data, input, P_UART_DATA_WIDTH, word to transmit.
REQ-010 i_user_tx_valid, input, 1, i_user_tx_data is valid.
REQ-011 o_user_tx_ready, output, 1, block can accept a word.
REQ-012 o_uart_tx, output, 1, serial line, idle high.

Function
REQ-013 Bit period N SHALL be P_SYSTEM_CLK / P_UART_BUADRATE (integer division); legal N is 2..65535; baud counter is 16 bits, counts 0..N-1, then wraps to 0.
REQ-014 Handshake SHALL occur on any rising edge where i_user_tx_valid and o_user_tx_ready are both 1; i_user_tx_data is captured into an internal register on that edge, and later input changes do not affect the frame.
REQ-015 States SHALL be IDLE, START, DATA, CHECK, STOP; o_user_tx_ready = 1 only in IDLE; all outputs registered.
REQ-016 IDLE: o_uart_tx = 1; on handshake go to START, same edge drives o_uart_tx <= 0 and o_user_tx_ready <= 0.
REQ-017 START: o_uart_tx = 0 for P_UART_START_WIDTH*N cycles, then DATA.
REQ-018 DATA: captured bits sent LSB first, each held N cycles; after bit P_UART_DATA_WIDTH-1, go to CHECK if P_UART_CHECK != 0, else STOP.
REQ-019 CHECK: one parity bit held N cycles, value per REQ-006 computed from captured word; then STOP.
REQ-020 STOP: o_uart_tx = 1 for P_UART_STOP_WIDTH*N cycles, then IDLE with o_user_tx_ready <= 1.
REQ-021 Frame length F = START + DATA + (P_UART_CHECK != 0 ? 1 : 0) + STOP bits; for handshake on edge k, line is low from edge k, IDLE/ready re-entered at edge k+F*N.
REQ-022 Earliest next handshake is edge k+F*N+1; back-to-back frames with i_user_tx_valid held high therefore have exactly one idle-high clock between them.
REQ-023 i_user_tx_valid while not ready SHALL be ignored (no queueing); word is not sent unless presented again when ready.
REQ-024 P_UART_CHECK values other than 0/1/2 SHALL behave as 0.

Reset
REQ-025 On i_rst = 1 at a rising edge: state <= IDLE, o_uart_tx <= 1, o_user_tx_ready <= 1, baud/bit counters and data register <= 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; line returns high on that edge and no residual bits are sent after reset releases.
REQ-027 A handshake on the same edge as i_rst = 1 SHALL be discarded.

Verification (P_SYSTEM_CLK=400, P_UART_BUADRATE=100 -> N=4, start 1, data 8, stop 1)
REQ-028 Even parity, send 0xA5 -> line 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1, each bit 4 clocks, ready low 44 clocks, high at k+44.
REQ-029 Odd parity (CHECK=2), send 0xA5 -> same frame with parity bit 1.
REQ-030 No parity (CHECK=0), send 0x00 -> 0 for 36 clocks then 1; ready returns at k+40.
REQ-031 Valid held high with 0x01 then 0x80 -> two complete frames, second start bit begins at edge k+45, one idle-high clock between.
REQ-032 Reset pulsed at edge k+10 of a frame -> o_uart_tx=1 and ready=1 from that edge; subsequent 0x3C sends a clean full frame.
REQ-033 Valid pulsed while busy with 0xFF -> ignored; line shows only the original frame, then stays high.
